// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit controller: state encoding, line levels, data width.
// PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

    localparam int DATA_W = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit generator: even (typ=0) or odd (typ=1) parity over one byte; purely combinational.
// Built only when UART_TX_PARITY_EN is defined; no backpressure.
`ifdef UART_TX_PARITY_EN
module uart_tx_parity_calc
    import uart_tx_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic              typ,
    output logic              par
);

    assign par = (^data) ^ typ;

endmodule
`endif

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte as start / 8 serializer bits / optional parity / stop.
// Latency: START one cycle after data_valid; accepts only in IDLE or on the last stop cycle.
// Parity support is compiled in with UART_TX_PARITY_EN.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int STOP_BITS = 1,
    parameter int WDOG_CYC  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] p_data,
`ifdef UART_TX_PARITY_EN
    input  logic              par_en,
    input  logic              par_typ,
`endif
    input  logic              ser_done,
    input  logic              ser_data,
    output logic              ser_en,
    output logic              ser_load,
    output logic [DATA_W-1:0] p_data_q,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_err
);

    localparam int                WD_W    = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_CYC - 1);

    state_t            state;
    logic              line;
    logic              stop_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              stop_last;
    logic              take;

    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
    assign take      = data_valid && ((state == ST_IDLE) || ((state == ST_STOP) && stop_last));

    // Data bits come straight from the serializer; every other level is registered.
    assign tx_out = ser_en ? ser_data : line;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_bit;

    uart_tx_parity_calc u_parity (
        .data (p_data_q),
        .typ  (par_typ_q),
        .par  (par_bit)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            line      <= LINE_IDLE;
            busy      <= 1'b0;
            ser_en    <= 1'b0;
            ser_load  <= 1'b0;
            frame_err <= 1'b0;
            p_data_q  <= '0;
            stop_cnt  <= 1'b0;
            wd_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            ser_load <= 1'b0;
            if (take) begin
                state     <= ST_START;
                line      <= LINE_START;
                busy      <= 1'b1;
                ser_load  <= 1'b1;
                frame_err <= 1'b0;
                p_data_q  <= p_data;
                stop_cnt  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        line <= LINE_IDLE;
                    end
                    ST_START: begin
                        state  <= ST_DATA;
                        ser_en <= 1'b1;
                        wd_cnt <= '0;
                    end
                    ST_DATA: begin
                        if (ser_done) begin
                            ser_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state <= ST_PARITY;
                                line  <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                line  <= LINE_STOP;
                            end
`else
                            state <= ST_STOP;
                            line  <= LINE_STOP;
`endif
                        end else if (wd_cnt == WD_LAST) begin
                            // Serializer stalled: close the frame with stop bits and flag it.
                            frame_err <= 1'b1;
                            ser_en    <= 1'b0;
                            state     <= ST_STOP;
                            line      <= LINE_STOP;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state <= ST_STOP;
                        line  <= LINE_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (stop_last) begin
                            stop_cnt <= 1'b0;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            line     <= LINE_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        ser_en <= 1'b0;
                        line   <= LINE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (STOP_BITS 1 and 2) against a frame-queue reference model.
module tb_uart_tx_ctrl;

    localparam int WDOG = 10;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct packed {
        logic tx;
        logic en;
        logic ld;
        logic se;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stall = 1'b0;
    logic       noise = 1'b0;

    logic [1:0] ser_en, ser_load, tx_out, busy, frame_err, ser_done, ser_data;
    logic [7:0] pdq [2];
    logic [7:0] sh [2];
    logic [4:0] cnt [2];

    rec_t       mq [2][$];
    logic       err_m [2];
    logic [7:0] pq_m [2];
    int         msz;
    rec_t       mr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.STOP_BITS(1), .WDOG_CYC(WDOG)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
`ifdef UART_TX_PARITY_EN
        .par_en     (par_en),
        .par_typ    (par_typ),
`endif
        .ser_done   (ser_done[0]),
        .ser_data   (ser_data[0]),
        .ser_en     (ser_en[0]),
        .ser_load   (ser_load[0]),
        .p_data_q   (pdq[0]),
        .tx_out     (tx_out[0]),
        .busy       (busy[0]),
        .frame_err  (frame_err[0])
    );

    uart_tx_ctrl #(.STOP_BITS(2), .WDOG_CYC(WDOG)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
`ifdef UART_TX_PARITY_EN
        .par_en     (par_en),
        .par_typ    (par_typ),
`endif
        .ser_done   (ser_done[1]),
        .ser_data   (ser_data[1]),
        .ser_en     (ser_en[1]),
        .ser_load   (ser_load[1]),
        .p_data_q   (pdq[1]),
        .tx_out     (tx_out[1]),
        .busy       (busy[1]),
        .frame_err  (frame_err[1])
    );

    // Serializer stand-in: LSB-first shifter, done on the 8th enabled cycle unless stalled.
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                sh[k]  <= 8'h00;
                cnt[k] <= 5'd0;
            end else if (ser_load[k]) begin
                sh[k]  <= pdq[k];
                cnt[k] <= 5'd0;
            end else if (ser_en[k]) begin
                cnt[k] <= cnt[k] + 5'd1;
            end
        end
    end

    always_comb begin
        ser_data = 2'b00;
        ser_done = 2'b00;
        for (int k = 0; k < 2; k++) begin
            ser_data[k] = sh[k][cnt[k][2:0]];
            ser_done[k] = ser_en[k] ? (!stall && cnt[k] == 5'd7) : noise;
        end
    end

    function automatic rec_t mk(input logic tx, input logic en, input logic ld, input logic se);
        rec_t r;
        r.tx = tx;
        r.en = en;
        r.ld = ld;
        r.se = se;
        return r;
    endfunction

    // Whole frame as a list of per-cycle expectations: start, data, optional parity, stop bits.
    function automatic void push_frame(input int k, input logic [7:0] b, input logic pe,
                                       input logic pt, input logic st);
        int nd;
        nd = st ? WDOG : 8;
        mq[k].push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < nd; i++)
            mq[k].push_back(mk(b[i % 8], 1'b1, 1'b0, st && (i == nd - 1)));
        if (!st && PAR_ON && pe)
            mq[k].push_back(mk((^b) ^ pt, 1'b0, 1'b0, 1'b0));
        for (int s = 0; s < k + 1; s++)
            mq[k].push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mq[k].delete();
                err_m[k] <= 1'b0;
                pq_m[k]  <= 8'h00;
            end else begin
                msz = mq[k].size();
                if (msz > 0) begin
                    mr = mq[k].pop_front();
                    if (mr.se) err_m[k] <= 1'b1;
                end
                if (data_valid && msz <= 1) begin
                    push_frame(k, p_data, par_en, par_typ, stall);
                    err_m[k] <= 1'b0;
                    pq_m[k]  <= p_data;
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                rec_t e;
                e = (mq[k].size() > 0) ? mq[k][0] : mk(1'b1, 1'b0, 1'b0, 1'b0);
                chk("tx_out",    k, 32'(tx_out[k]),    32'(e.tx));
                chk("busy",      k, 32'(busy[k]),      32'(mq[k].size() > 0));
                chk("ser_en",    k, 32'(ser_en[k]),    32'(e.en));
                chk("ser_load",  k, 32'(ser_load[k]),  32'(e.ld));
                chk("frame_err", k, 32'(frame_err[k]), 32'(err_m[k]));
                chk("p_data_q",  k, 32'(pdq[k]),       32'(pq_m[k]));
            end
        end
    end

    task automatic step(input logic dv, input logic [7:0] d);
        @(negedge clk);
        #2;
        data_valid = dv;
        p_data     = d;
    endtask

    // Offers b1, optionally holds data_valid with b2 for 'hold' cycles, and records each
    // instance's tx_out per cycle and the first cycle it is no longer busy.
    task automatic send(input logic [7:0] b1, input logic [7:0] b2, input int hold,
                        output int fi0, output int fi1,
                        output logic [31:0] s0, output logic [31:0] s1);
        fi0 = -1;
        fi1 = -1;
        s0  = '0;
        s1  = '0;
        step(1'b1, b1);
        for (int i = 0; i < 60; i++) begin
            step(i < hold, b2);
            if (i < 32) begin
                s0[i] = tx_out[0];
                s1[i] = tx_out[1];
            end
            if (fi0 < 0 && !busy[0]) fi0 = i;
            if (fi1 < 0 && !busy[1]) fi1 = i;
            if (fi0 >= 0 && fi1 >= 0) break;
        end
        data_valid = 1'b0;
        if (fi0 < 0 || fi1 < 0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got fi0=%0d fi1=%0d expected frame end within 60 cycles", fi0, fi1);
        end
    endtask

    int          f0, f1;
    logic [31:0] q0, q1;

    initial begin
        repeat (2) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx",       k, 32'(tx_out[k]),    32'd1);
            chk("rst_busy",     k, 32'(busy[k]),      32'd0);
            chk("rst_ser_en",   k, 32'(ser_en[k]),    32'd0);
            chk("rst_ser_load", k, 32'(ser_load[k]),  32'd0);
            chk("rst_ferr",     k, 32'(frame_err[k]), 32'd0);
            chk("rst_pdq",      k, 32'(pdq[k]),       32'd0);
        end
        rst = 1'b1;

        send(8'hA5, 8'h00, 0, f0, f1, q0, q1);
        chk("a5_len",  0, 32'(f0), 32'd10);
        chk("a5_seq",  0, {22'd0, q0[9:0]}, 32'h34A);
        chk("a5_len",  1, 32'(f1), 32'd11);
        chk("a5_seq",  1, {21'd0, q1[10:0]}, 32'h74A);

`ifdef UART_TX_PARITY_EN
        par_en  = 1'b1;
        par_typ = 1'b0;
        send(8'hA5, 8'h00, 0, f0, f1, q0, q1);
        chk("par_even_len", 0, 32'(f0), 32'd11);
        chk("par_even_bit", 0, 32'(q0[9]), 32'd0);
        chk("par_even_stop", 0, 32'(q0[10]), 32'd1);
        par_typ = 1'b1;
        send(8'hA5, 8'h00, 0, f0, f1, q0, q1);
        chk("par_odd_len", 0, 32'(f0), 32'd11);
        chk("par_odd_bit", 0, 32'(q0[9]), 32'd1);
        par_en  = 1'b0;
        par_typ = 1'b0;
`endif

        send(8'h00, 8'h00, 0, f0, f1, q0, q1);
        chk("zero_seq", 1, {21'd0, q1[10:0]}, 32'h600);
        chk("zero_len", 1, 32'(f1), 32'd11);
        chk("zero_seq", 0, {22'd0, q0[9:0]}, 32'h200);

        send(8'h3C, 8'hFF, 12, f0, f1, q0, q1);
        chk("b2b_len", 0, 32'(f0), 32'd20);
        chk("b2b_len", 1, 32'(f1), 32'd22);
        chk("b2b_seq", 0, {12'd0, q0[19:0]}, 32'hFFA78);

        stall = 1'b1;
        send(8'h5A, 8'h00, 0, f0, f1, q0, q1);
        chk("stall_len",  0, 32'(f0), 32'd12);
        chk("stall_len",  1, 32'(f1), 32'd13);
        chk("stall_ferr", 0, 32'(frame_err[0]), 32'd1);
        chk("stall_ferr", 1, 32'(frame_err[1]), 32'd1);
        stall = 1'b0;
        send(8'h81, 8'h00, 0, f0, f1, q0, q1);
        chk("ferr_clear", 0, 32'(frame_err[0]), 32'd0);
        chk("ferr_clear", 1, 32'(frame_err[1]), 32'd0);

        // Abort a frame while a zero data bit is on the line.
        step(1'b1, 8'h80);
        repeat (4) step(1'b0, 8'h00);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_tx",   k, 32'(tx_out[k]), 32'd1);
            chk("abort_busy", k, 32'(busy[k]),   32'd0);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        send(8'h01, 8'h00, 0, f0, f1, q0, q1);
        chk("post_rst_len", 0, 32'(f0), 32'd10);
        chk("post_rst_seq", 0, {22'd0, q0[9:0]}, 32'h202);
        chk("post_rst_len", 1, 32'(f1), 32'd11);

        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 3) == 0, 8'($urandom));
            par_en  = 1'($urandom);
            par_typ = 1'($urandom);
            noise   = 1'($urandom);
        end
        data_valid = 1'b0;
        noise      = 1'b0;
        repeat (30) @(negedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop-bit cycles (legal values 1 or 2).
REQ-002 SHALL have parameter WDOG_CYC, default 10, maximum DATA-state cycles before the serializer is declared stalled.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_valid  input  1  a new byte is offered on p_data.
REQ-006 SHALL have port p_data  input  8  byte to transmit.
REQ-007 SHALL have port par_en  input  1  parity bit enable (present only with UART_TX_PARITY_EN).
REQ-008 SHALL have port par_typ  input  1  parity type, 0 even, 1 odd (present only with UART_TX_PARITY_EN).
REQ-009 SHALL have port ser_done  input  1  serializer finished shifting 8 bits.
REQ-010 SHALL have port ser_data  input  1  current serial data bit from the serializer.
REQ-011 SHALL have port ser_en  output  1  enables serializer shifting.
REQ-012 SHALL have port ser_load  output  1  one-cycle pulse; the serializer captures p_data_q.
REQ-013 SHALL have port p_data_q  output  8  latched byte presented to the serializer.
REQ-014 SHALL have port tx_out  output  1  UART line, idle high.
REQ-015 SHALL have port busy  output  1  a frame is in progress.
REQ-016 SHALL have port frame_err  output  1  sticky serializer-stall flag.

Function
REQ-017 SHALL implement the states IDLE, START, DATA, PARITY and STOP, with registered outputs decoded from the state.
REQ-018 IDLE SHALL drive tx_out=1, busy=0 and ser_en=0.
REQ-019 In IDLE, data_valid=1 at a clock edge SHALL latch p_data into p_data_q, pulse ser_load for that cycle, clear frame_err, and move to START.
REQ-020 START SHALL last exactly 1 cycle with tx_out=0, busy=1, then move to DATA.
REQ-021 DATA SHALL drive ser_en=1 and tx_out=ser_data.
REQ-022 DATA SHALL exit on the first cycle with ser_done=1: to PARITY if par_en=1, otherwise to STOP.
REQ-023 A DATA dwell reaching WDOG_CYC cycles without ser_done SHALL set frame_err=1 and force the state to STOP.
REQ-024 PARITY SHALL last 1 cycle with tx_out = XOR of p_data_q (par_typ=0), or its inverse (par_typ=1).
REQ-025 STOP SHALL drive tx_out=1 for STOP_BITS cycles, counted with a 1-bit counter that wraps to 0 on exit.
REQ-026 data_valid=1 on the last STOP cycle SHALL latch and load as in REQ-019 and go directly to START (back-to-back, no idle cycle); otherwise the FSM SHALL go to IDLE.
REQ-027 data_valid SHALL be ignored in START, DATA and PARITY, and in STOP cycles other than the last; p_data_q SHALL stay stable for the whole frame.
REQ-028 par_en and par_typ SHALL be sampled only at frame acceptance and held for the frame.
REQ-029 ser_done asserted in any state other than DATA SHALL be ignored.
REQ-030 Frame length SHALL be 1+8+P+STOP_BITS cycles, where P=1 with parity and P=0 without.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE, tx_out=1, busy=0, ser_en=0, ser_load=0, frame_err=0, p_data_q=0, counters=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no partial stop bits; after release the block SHALL wait in IDLE for data_valid.

Configuration
REQ-033 Macro UART_TX_PARITY_EN defined: par_en and par_typ ports exist and the PARITY state is reachable.
REQ-034 Macro UART_TX_PARITY_EN undefined: the par_en and par_typ ports and the PARITY state SHALL be absent, and the frame SHALL always be 8N(STOP_BITS).

Structure
REQ-035 A shared package uart_tx_pkg SHALL hold the state encoding, the IDLE/START/STOP line-level constants and the data width constant of 8.
REQ-036 Parity generation SHALL be a sub-module uart_tx_parity_calc (byte, type, parity bit); everything else SHALL be flat.

Verification
REQ-037 0xA5, par_en=0, STOP_BITS=1 -> tx_out sequence 0, then serializer bits, then 1; busy high for 10 cycles.
REQ-038 0xA5, par_en=1, par_typ=0 -> parity bit 0; with par_typ=1 -> parity bit 1; busy high for 11 cycles.
REQ-039 0x3C followed by 0xFF offered with data_valid held high -> second START immediately after the first stop bit, with no idle cycle.
REQ-040 ser_done tied low -> frame_err=1 after 10 DATA cycles, then STOP, then IDLE; next accepted byte clears frame_err.
REQ-041 rst pulsed low during DATA -> tx_out=1 and busy=0 in the same cycle; a byte of 0x01 sent after release completes correctly.
REQ-042 STOP_BITS=2, 0x00, macro undefined -> tx_out low for 9 cycles, then high for 2 cycles.
